display_timing: RTL and testbench
=================================

// Module: display_timing
// PURPOSE
//   Raster timing generator for a VGA-style display, clocked by the pixel clock.
//   Keeps free-running pixel (col) and line (row) counters.
//   Decodes horizontal and vertical phase flags (front porch, sync, back porch) and an active-video flag.
//   Sits between the pixel-clock source and the video output/pixel-fetch logic.
// PARAMETERS
//   H_ACTIVE  640  visible pixels per line
//   H_FRONT   16   horizontal front-porch pixels
//   H_SYNC    96   horizontal sync pixels
//   H_BACK    48   horizontal back-porch pixels
//   V_ACTIVE  480  visible lines per frame
//   V_FRONT   10   vertical front-porch lines
//   V_SYNC    2    vertical sync lines
//   V_BACK    33   vertical back-porch lines
// PORTS
//   pixelclk   in   1   pixel clock; the only clock, all logic on its rising edge
//   rst_n      in   1   synchronous reset, active low
//   hfront     out  1   high while col is in the horizontal front porch
//   hsync      out  1   high while col is in horizontal sync (active-high flag, not pin polarity)
//   hback      out  1   high while col is in the horizontal back porch
//   vfront     out  1   high while row is in the vertical front porch
//   vsync      out  1   high while row is in vertical sync
//   vback      out  1   high while row is in the vertical back porch
//   indisplay  out  1   high when both col and row are in their active regions
//   row        out  16  current line counter, 0..V_TOTAL-1
//   col        out  16  current pixel counter within the line, 0..H_TOTAL-1
// BEHAVIOUR
//   - H_TOTAL = sum of the four H_ parameters (800 by default).
//   - V_TOTAL = sum of the four V_ parameters (525 by default).
//   - Line order: active, front porch, sync, back porch. Frame order is the same.
//   - Counters: col and row are registers, updated on the rising edge of pixelclk.
//     - rst_n low at an edge sets col=0 and row=0. This takes priority and also applies mid-frame.
//     - Otherwise col increments every cycle.
//     - When col==H_TOTAL-1, col wraps to 0 and row increments on the same edge.
//     - When row==V_TOTAL-1 and col==H_TOTAL-1, both wrap to 0 on the same edge.
//   - Flags are combinational decodes of the current col/row registers, so they align with row/col in the same cycle (zero latency).
//   - Horizontal decode:
//     - active: col < H_ACTIVE
//     - hfront: H_ACTIVE <= col < H_ACTIVE+H_FRONT
//     - hsync: H_ACTIVE+H_FRONT <= col < H_ACTIVE+H_FRONT+H_SYNC
//     - hback: the remaining cols, up to H_TOTAL-1
//   - Vertical decode: identical, using row and the V_ parameters.
//   - Exactly one horizontal phase (active/hfront/hsync/hback) is true each cycle. The same holds vertically.
//   - Horizontal flags are independent of the vertical phase.
//   - indisplay = horizontal-active AND vertical-active.
//   - Output values after reset (col=0, row=0):
//     - indisplay=1
//     - all six porch/sync flags 0
//     - row=0, col=0
//   - Counter widths are 16 bits. Parameters must give H_TOTAL and V_TOTAL <= 65536, with every phase length >= 1.
//   - No handshakes and no enables. The counters free-run whenever rst_n is high.
// TESTING
//   1. Hold rst_n=0 for 3 clocks -> row=0, col=0, indisplay=1, all flags 0. Release -> col=1 one clock later.
//   2. Run a full line -> hfront high for col 640..655, hsync for 656..751, hback for 752..799, indisplay for col 0..639.
//   3. At col=799 -> next cycle col=0 and row increments by 1. Check the hsync->hback->active sequence across the wrap.
//   4. Run a full frame -> vfront for rows 480..489, vsync for 490..491, vback for 492..524. indisplay=0 for rows >= 480.
//   5. At row=524, col=799 -> next cycle row=0, col=0, indisplay=1. Frame length is 800*525 = 420000 clocks.
//   6. Assert rst_n=0 mid-line (e.g. row=100, col=700) -> the next edge gives row=0, col=0. Checker: the one-hot phase property holds every cycle.

Source files
------------

// File: rtl/display_timing_if.sv
// rtl/display_timing_if.sv - raster position and phase flags bundle
interface display_timing_if;
  logic        hfront;
  logic        hsync;
  logic        hback;
  logic        vfront;
  logic        vsync;
  logic        vback;
  logic        indisplay;
  logic [15:0] row;
  logic [15:0] col;

  modport master (output hfront, hsync, hback, vfront, vsync, vback, indisplay, row, col);
  modport slave  (input  hfront, hsync, hback, vfront, vsync, vback, indisplay, row, col);
endinterface

// File: rtl/display_timing.sv
// rtl/display_timing.sv - free-running VGA-style raster counters with phase decode
module display_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic              pixelclk,
  input  logic              rst_n,
  display_timing_if.master  vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Phase boundaries: each is the first position of the named phase.
  localparam logic [15:0] H_FP_START   = 16'(H_ACTIVE);
  localparam logic [15:0] H_SYNC_START = 16'(H_ACTIVE + H_FRONT);
  localparam logic [15:0] H_BP_START   = 16'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [15:0] H_LAST       = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_FP_START   = 16'(V_ACTIVE);
  localparam logic [15:0] V_SYNC_START = 16'(V_ACTIVE + V_FRONT);
  localparam logic [15:0] V_BP_START   = 16'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [15:0] V_LAST       = 16'(V_TOTAL - 1);

  logic [15:0] col_q, col_d;
  logic [15:0] row_q, row_d;
  logic        h_active;
  logic        v_active;

  always_comb begin
    col_d = col_q + 16'd1;
    row_d = row_q;
    if (col_q == H_LAST) begin
      col_d = 16'd0;
      row_d = (row_q == V_LAST) ? 16'd0 : row_q + 16'd1;
    end
  end

  always_ff @(posedge pixelclk) begin
    if (!rst_n) begin
      col_q <= 16'd0;
      row_q <= 16'd0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Flags decode the registered counters directly so they line up with row/col.
  always_comb begin
    h_active      = (col_q < H_FP_START);
    v_active      = (row_q < V_FP_START);
    vid.hfront    = (col_q >= H_FP_START)   && (col_q < H_SYNC_START);
    vid.hsync     = (col_q >= H_SYNC_START) && (col_q < H_BP_START);
    vid.hback     = (col_q >= H_BP_START);
    vid.vfront    = (row_q >= V_FP_START)   && (row_q < V_SYNC_START);
    vid.vsync     = (row_q >= V_SYNC_START) && (row_q < V_BP_START);
    vid.vback     = (row_q >= V_BP_START);
    vid.indisplay = h_active && v_active;
    vid.row       = row_q;
    vid.col       = col_q;
  end
endmodule

// File: tb/tb_display_timing.sv
// tb/tb_display_timing.sv - randomized self-checking bench for display_timing
module tb_display_timing;
  localparam int BHA = 640, BHF = 16, BHS = 96, BHB = 48;
  localparam int BVA = 480, BVF = 10, BVS = 2,  BVB = 33;
  localparam int BHT = BHA + BHF + BHS + BHB;
  localparam int BVT = BVA + BVF + BVS + BVB;
  localparam int SHA = 10, SHF = 2, SHS = 3, SHB = 4;
  localparam int SVA = 5,  SVF = 2, SVS = 1, SVB = 3;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;

  logic   pixelclk = 1'b0;
  logic   rst_n = 1'b0;
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  always #5 pixelclk = ~pixelclk;

  display_timing_if big_if ();
  display_timing_if small_if ();

  display_timing dut_big (
    .pixelclk (pixelclk),
    .rst_n    (rst_n),
    .vid      (big_if)
  );

  display_timing #(
    .H_ACTIVE (SHA), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
    .V_ACTIVE (SVA), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB)
  ) dut_small (
    .pixelclk (pixelclk),
    .rst_n    (rst_n),
    .vid      (small_if)
  );

  // Rising edges since reset was last released.
  always @(posedge pixelclk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Phase index of a position: 0 active, 1 front porch, 2 sync, 3 back porch.
  function automatic int phase_of(int pos, int a, int f, int s);
    if (pos < a)         return 0;
    if (pos < a + f)     return 1;
    if (pos < a + f + s) return 2;
    return 3;
  endfunction

  // Expected {vback,vsync,vfront,hback,hsync,hfront,indisplay} after c cycles.
  function automatic logic [6:0] exp_flags(longint c, int ha, int hf, int hs, int hb,
                                           int va, int vf, int vs, int vb);
    int ht, vt, x, y, hp, vp;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    x  = int'(c % ht);
    y  = int'((c / ht) % vt);
    hp = phase_of(x, ha, hf, hs);
    vp = phase_of(y, va, vf, vs);
    return {vp == 3, vp == 2, vp == 1, hp == 3, hp == 2, hp == 1, (hp == 0) && (vp == 0)};
  endfunction

  function automatic logic [6:0] big_flags();
    return {big_if.vback, big_if.vsync, big_if.vfront, big_if.hback,
            big_if.hsync, big_if.hfront, big_if.indisplay};
  endfunction

  function automatic logic [6:0] small_flags();
    return {small_if.vback, small_if.vsync, small_if.vfront, small_if.hback,
            small_if.hsync, small_if.hfront, small_if.indisplay};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge pixelclk);
    checks++;
    if (big_if.row !== 16'd0 || big_if.col !== 16'd0) begin
      errors++;
      $display("FAIL reset_pos big row=%0d col=%0d expected 0 0", big_if.row, big_if.col);
    end
    checks++;
    if (big_flags() !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_flags big got %b expected 0000001", big_flags());
    end
    checks++;
    if (small_if.row !== 16'd0 || small_if.col !== 16'd0 || small_flags() !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_small row=%0d col=%0d flags=%b expected 0 0 0000001",
               small_if.row, small_if.col, small_flags());
    end
    rst_n = 1'b1;
    @(negedge pixelclk);
    checks++;
    if (big_if.col !== 16'd1 || big_if.row !== 16'd0) begin
      errors++;
      $display("FAIL reset_release col=%0d row=%0d expected 1 0", big_if.col, big_if.row);
    end
  endtask

  // Two full lines of the default timing, every cycle checked against the model.
  task automatic test_line();
    logic [6:0] e;
    for (int i = 0; i < 2 * BHT; i++) begin
      e = exp_flags(cyc, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB);
      checks++;
      if (big_flags() !== e) begin
        errors++;
        $display("FAIL line_flags col=%0d got %b expected %b", big_if.col, big_flags(), e);
      end
      checks++;
      if (big_if.col !== 16'(cyc % BHT) || big_if.row !== 16'((cyc / BHT) % BVT)) begin
        errors++;
        $display("FAIL line_pos got %0d/%0d expected %0d/%0d", big_if.row, big_if.col,
                 (cyc / BHT) % BVT, cyc % BHT);
      end
      @(negedge pixelclk);
    end
  endtask

  task automatic test_line_wrap();
    logic [15:0] r;
    int guard;
    guard = 0;
    while ((cyc % BHT) != BHT - 2 && guard < BHT) begin
      @(negedge pixelclk);
      guard++;
    end
    checks++;
    if (guard >= BHT) begin
      errors++;
      $display("FAIL wrap_bound cycle budget expired");
    end
    r = 16'((cyc / BHT) % BVT);
    @(negedge pixelclk);
    checks++;
    if (big_if.col !== 16'(BHT - 1) || big_if.hback !== 1'b1 || big_if.hsync !== 1'b0) begin
      errors++;
      $display("FAIL wrap_last col=%0d hback=%b hsync=%b expected %0d 1 0",
               big_if.col, big_if.hback, big_if.hsync, BHT - 1);
    end
    @(negedge pixelclk);
    checks++;
    if (big_if.col !== 16'd0 || big_if.row !== r + 16'd1 ||
        big_if.indisplay !== 1'b1 || big_if.hback !== 1'b0) begin
      errors++;
      $display("FAIL wrap_first row=%0d col=%0d ind=%b hback=%b expected %0d 0 1 0",
               big_if.row, big_if.col, big_if.indisplay, big_if.hback, r + 16'd1);
    end
  endtask

  // Scaled-down timing: two full frames with position, flags and one-hot checks.
  task automatic test_frame();
    logic [6:0] e;
    rst_n = 1'b0;
    @(negedge pixelclk);
    rst_n = 1'b1;
    @(negedge pixelclk);
    for (int i = 0; i < 2 * SHT * SVT + 3; i++) begin
      e = exp_flags(cyc, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB);
      checks++;
      if (small_flags() !== e) begin
        errors++;
        $display("FAIL frame_flags row=%0d col=%0d got %b expected %b",
                 small_if.row, small_if.col, small_flags(), e);
      end
      checks++;
      if (small_if.col !== 16'(cyc % SHT) || small_if.row !== 16'((cyc / SHT) % SVT)) begin
        errors++;
        $display("FAIL frame_pos got %0d/%0d expected %0d/%0d", small_if.row, small_if.col,
                 (cyc / SHT) % SVT, cyc % SHT);
      end
      checks++;
      if ($countones({small_if.hfront, small_if.hsync, small_if.hback}) > 1 ||
          $countones({small_if.vfront, small_if.vsync, small_if.vback}) > 1) begin
        errors++;
        $display("FAIL frame_onehot h=%b%b%b v=%b%b%b expected at most one set",
                 small_if.hfront, small_if.hsync, small_if.hback,
                 small_if.vfront, small_if.vsync, small_if.vback);
      end
      if (cyc == longint'(SHT * SVT)) begin
        checks++;
        if (small_if.row !== 16'd0 || small_if.col !== 16'd0 || small_if.indisplay !== 1'b1) begin
          errors++;
          $display("FAIL frame_wrap row=%0d col=%0d ind=%b expected 0 0 1",
                   small_if.row, small_if.col, small_if.indisplay);
        end
      end
      @(negedge pixelclk);
    end
  endtask

  // Random free-run windows on the default timing, then a mid-frame reset.
  task automatic test_mid_reset();
    int n;
    logic [6:0] e;
    for (int k = 0; k < 5; k++) begin
      n = int'($urandom_range(50, 3000));
      for (int i = 0; i < n; i++) begin
        e = exp_flags(cyc, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB);
        checks++;
        if (big_flags() !== e || big_if.col !== 16'(cyc % BHT) ||
            big_if.row !== 16'((cyc / BHT) % BVT)) begin
          errors++;
          $display("FAIL run_big got %0d/%0d %b expected %0d/%0d %b", big_if.row, big_if.col,
                   big_flags(), (cyc / BHT) % BVT, cyc % BHT, e);
        end
        @(negedge pixelclk);
      end
      rst_n = 1'b0;
      @(negedge pixelclk);
      checks++;
      if (big_if.row !== 16'd0 || big_if.col !== 16'd0 ||
          small_if.row !== 16'd0 || small_if.col !== 16'd0) begin
        errors++;
        $display("FAIL mid_reset big=%0d/%0d small=%0d/%0d expected 0/0",
                 big_if.row, big_if.col, small_if.row, small_if.col);
      end
      rst_n = 1'b1;
      @(negedge pixelclk);
      checks++;
      if (big_if.col !== 16'd1 || small_if.col !== 16'd1) begin
        errors++;
        $display("FAIL mid_release big col=%0d small col=%0d expected 1", big_if.col, small_if.col);
      end
    end
  endtask

  initial begin
    @(negedge pixelclk);
    test_reset();
    test_line();
    test_line_wrap();
    test_frame();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
